// File: rtl/tdm_channel_mixer.sv
// tdm_channel_mixer: scans CHANNELS time-multiplexed voice slots once per
// frame, scales each slot by a runtime-writable per-channel gain (with mute),
// accumulates, applies a master attenuation shift and emits one mixed sample.
// Build option: define MIXER_SATURATE_EN to clamp the final sample instead of
// wrapping it to SAMPLE_W bits.
module tdm_channel_mixer #(
    parameter int CHANNELS     = 8,
    parameter int SAMPLE_W     = 16,
    parameter int GAIN_W       = 8,
    parameter int MASTER_SHIFT = 3
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        FRAME_START,
    output logic [$clog2(CHANNELS)-1:0] SLOT,
    output logic                        SLOT_VALID,
    input  logic signed [SAMPLE_W-1:0]  SAMPLE_IN,
    input  logic [CHANNELS-1:0]         MUTE,
    input  logic                        GAIN_WE,
    input  logic [$clog2(CHANNELS)-1:0] GAIN_ADDR,
    input  logic [GAIN_W-1:0]           GAIN_DATA,
    output logic signed [SAMPLE_W-1:0]  OUT,
    output logic                        OUT_VALID,
    output logic                        BUSY,
    output logic                        OVERRUN
);

    localparam int SW     = $clog2(CHANNELS);
    localparam int ACC_W  = SAMPLE_W + SW;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

`ifdef MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(SW + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(SW + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}});
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [GAIN_W-1:0]          gain_tbl [CHANNELS];
    logic signed [SAMPLE_W-1:0] prod_p0;
    logic signed [SAMPLE_W-1:0] prod_p1;
    logic                       vld_p1;
    logic signed [ACC_W-1:0]    acc_p2;

    // Signed sample times unsigned gain, floored back to SAMPLE_W (gain < 1 so it cannot overflow).
    function automatic logic signed [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] smp,
        input logic [GAIN_W-1:0]          g
    );
        logic signed [PROD_W-1:0] m;
        m = $signed({{(GAIN_W + 1){smp[SAMPLE_W-1]}}, smp}) * $signed({{(SAMPLE_W + 1){1'b0}}, g});
        m = m >>> GAIN_W;
        return m[SAMPLE_W-1:0];
    endfunction

    // Master attenuation followed by either clamping or legacy two's-complement wrap.
    function automatic logic signed [SAMPLE_W-1:0] fit(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> MASTER_SHIFT;
`ifdef MIXER_SATURATE_EN
        if (s > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return s[SAMPLE_W-1:0];
`else
        return s[SAMPLE_W-1:0];
`endif
    endfunction

    assign SLOT_VALID = (state_q == SCAN);
    assign BUSY       = (state_q != IDLE);

    // Slot read: gain lookup and mute applied to the sample presented this cycle.
    always_comb begin
        prod_p0 = '0;
        if (!MUTE[SLOT])
            prod_p0 = scale_sample(SAMPLE_IN, gain_tbl[SLOT]);
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (FRAME_START) state_d = SCAN;
            SCAN:    if (SLOT == LAST_SLOT) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gain table: reset to full scale, written at any time, read sees the pre-write value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++)
                gain_tbl[i] <= '1;
        end else if (GAIN_WE) begin
            gain_tbl[GAIN_ADDR] <= GAIN_DATA;
        end
    end

    // Sequencer state, product/accumulate pipeline and output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            SLOT      <= '0;
            prod_p1   <= '0;
            vld_p1    <= 1'b0;
            acc_p2    <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state_q   <= state_d;
            OUT_VALID <= 1'b0;
            OVERRUN   <= FRAME_START && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (FRAME_START) begin
                        acc_p2 <= '0;
                        SLOT   <= '0;
                        vld_p1 <= 1'b0;
                    end
                end
                SCAN: begin
                    prod_p1 <= prod_p0;
                    vld_p1  <= 1'b1;
                    if (vld_p1)
                        acc_p2 <= acc_p2 + $signed({{SW{prod_p1[SAMPLE_W-1]}}, prod_p1});
                    if (SLOT != LAST_SLOT)
                        SLOT <= SLOT + 1'b1;
                end
                DRAIN: begin
                    acc_p2 <= acc_p2 + $signed({{SW{prod_p1[SAMPLE_W-1]}}, prod_p1});
                    vld_p1 <= 1'b0;
                end
                DONE: begin
                    OUT       <= fit(acc_p2);
                    OUT_VALID <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_channel_mixer.sv
// Bench for tdm_channel_mixer: two instances (master shift 3 and 0) run in
// lockstep; a reference model pushes expected results at frame start and the
// output monitor pops and compares them on every OUT_VALID.
module tb_tdm_channel_mixer;

    localparam int CH  = 8;
    localparam int SW  = 16;
    localparam int GW  = 8;
    localparam int SLW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 frame_start;
    logic                 gain_we;
    logic [CH-1:0]        mute;
    logic [SLW-1:0]       gain_addr;
    logic [GW-1:0]        gain_data;
    logic [SLW-1:0]       slot, slot_s0;
    logic                 slot_valid, slot_valid_s0;
    logic signed [SW-1:0] sample_in, sample_in_s0;
    logic signed [SW-1:0] out, out_s0;
    logic                 out_valid, out_valid_s0;
    logic                 busy, busy_s0;
    logic                 overrun, overrun_s0;

    int slot_val [CH];
    int gain_m   [CH];

    typedef struct {
        longint e3;
        longint e0;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    always_comb begin
        sample_in    = SW'(slot_val[slot]);
        sample_in_s0 = SW'(slot_val[slot_s0]);
    end

    tdm_channel_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW), .MASTER_SHIFT(3)) u_dut (
        .CLK(clk), .RESET(rst), .FRAME_START(frame_start),
        .SLOT(slot), .SLOT_VALID(slot_valid), .SAMPLE_IN(sample_in), .MUTE(mute),
        .GAIN_WE(gain_we), .GAIN_ADDR(gain_addr), .GAIN_DATA(gain_data),
        .OUT(out), .OUT_VALID(out_valid), .BUSY(busy), .OVERRUN(overrun)
    );

    tdm_channel_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW), .MASTER_SHIFT(0)) u_dut_s0 (
        .CLK(clk), .RESET(rst), .FRAME_START(frame_start),
        .SLOT(slot_s0), .SLOT_VALID(slot_valid_s0), .SAMPLE_IN(sample_in_s0), .MUTE(mute),
        .GAIN_WE(gain_we), .GAIN_ADDR(gain_addr), .GAIN_DATA(gain_data),
        .OUT(out_s0), .OUT_VALID(out_valid_s0), .BUSY(busy_s0), .OVERRUN(overrun_s0)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fit_m(input longint v, input int sh);
        longint s;
        logic signed [15:0] t;
        s = v >>> sh;
`ifdef MIXER_SATURATE_EN
        t = '0;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        t = s[15:0];
        return longint'(t);
`endif
    endfunction

    function automatic exp_t model();
        exp_t r;
        longint sum;
        sum = 0;
        for (int k = 0; k < CH; k++)
            if (!mute[k])
                sum += (longint'(slot_val[k]) * longint'(gain_m[k])) >>> GW;
        r.e3 = fit_m(sum, 3);
        r.e0 = fit_m(sum, 0);
        return r;
    endfunction

    // Output monitor: every OUT_VALID must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e_pop = sb.pop_front();
                check("out", out, e_pop.e3);
                check("out_s0", out_s0, e_pop.e0);
                check("out_valid_s0", out_valid_s0, 1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < CH; k++) slot_val[k] = v;
    endtask

    task automatic write_gain(input int a, input int d);
        gain_we   = 1'b1;
        gain_addr = SLW'(a);
        gain_data = GW'(d);
        tick();
        gain_we   = 1'b0;
        gain_m[a] = d;
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check(tag, 0, 1);
    endtask

    task automatic wait_slot(input int k);
        bit seen;
        seen = slot_valid && (slot == SLW'(k));
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (slot_valid && (slot == SLW'(k))) seen = 1'b1;
        end
        if (!seen) check("wait_slot_timeout", 0, 1);
    endtask

    // Called a little after an edge with the mixer idle (or idle at the next edge).
    task automatic run_frame(input bit chk_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        frame_start = 1'b1;
        sb.push_back(model());
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            frame_start = 1'b0;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("frame_timeout", 0, 1);
        else if (chk_lat) check("latency", lat, CH + 3);
    endtask

    int nv0;

    initial begin
        rst = 1'b1; frame_start = 1'b0; gain_we = 1'b0;
        gain_addr = '0; gain_data = '0; mute = '0;
        for (int k = 0; k < CH; k++) begin
            slot_val[k] = 0;
            gain_m[k]   = 255;
        end

        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_slot_valid", slot_valid, 0);
        check("rst_slot", slot, 0);
        check("rst_busy_s0", busy_s0, 0);
        check("rst_slot_valid_s0", slot_valid_s0, 0);
        tick();
        set_all(256);
        run_frame(1'b0);
        check("default_gain_out", out, 255);

        // Unity mix, latency, one-cycle valid, output hold
        set_all(1000);
        run_frame(1'b1);
        tick();
        check("out_valid_pulse", out_valid, 0);
        check("out_hold", out, 996);

        // Slot sequencing
        frame_start = 1'b1;
        sb.push_back(model());
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < CH; k++) begin
            check("scan_slot", slot, k);
            check("scan_slot_valid", slot_valid, 1);
            check("scan_busy", busy, 1);
            tick();
        end
        check("drain_slot_valid", slot_valid, 0);
        check("drain_slot_hold", slot, CH - 1);
        tick(); tick();
        check("seq_out_valid", out_valid, 1);

        // Back-to-back frame accepted in the idle cycle after DONE
        run_frame(1'b1);
        check("b2b_overrun", overrun, 0);

        // Mute and gain
        write_gain(0, 128);
        set_all(5000);
        slot_val[0] = -2000;
        mute = 8'hFE;
        run_frame(1'b0);
        check("mute_gain_out", out, -125);
        mute = '0;
        write_gain(0, 255);

        // Gain write to the slot being read uses the old value
        set_all(1000);
        frame_start = 1'b1;
        sb.push_back(model());
        tick();
        frame_start = 1'b0;
        wait_slot(3);
        gain_we = 1'b1; gain_addr = 3'd3; gain_data = 8'd0;
        tick();
        gain_we = 1'b0;
        gain_m[3] = 0;
        wait_valid("rbw_timeout");
        tick();
        run_frame(1'b0);
        write_gain(3, 255);

        // Full-scale positive and negative (saturate / wrap on the shift-0 instance)
        set_all(32767);
        run_frame(1'b0);
        set_all(-32768);
        run_frame(1'b0);

        // Random samples, gains and mutes
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < CH; k++) begin
                slot_val[k] = int'($urandom_range(0, 65535)) - 32768;
                write_gain(k, int'($urandom_range(0, 255)));
            end
            mute = CH'($urandom);
            run_frame(1'b0);
        end
        mute = '0;
        for (int k = 0; k < CH; k++) write_gain(k, 255);

        // Overrun
        set_all(1000);
        tick();
        nv0 = n_valid;
        frame_start = 1'b1;
        sb.push_back(model());
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("overrun_pulse", overrun, 1);
        check("overrun_pulse_s0", overrun_s0, 1);
        tick();
        check("overrun_clear", overrun, 0);
        wait_valid("overrun_timeout");
        repeat (15) tick();
        check("overrun_valid_count", n_valid - nv0, 1);

        // Reset mid-scan, with a non-default gain that reset must restore
        write_gain(2, 10);
        frame_start = 1'b1;
        sb.push_back(model());
        tick();
        frame_start = 1'b0;
        wait_slot(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < CH; k++) gain_m[k] = 255;
        check("midrst_busy", busy, 0);
        check("midrst_out", out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_slot_valid", slot_valid, 0);
        check("midrst_slot", slot, 0);
        nv0 = n_valid;
        repeat (15) tick();
        check("midrst_no_valid", n_valid - nv0, 0);
        run_frame(1'b1);
        check("post_rst_out", out, 996);

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
